// File: rtl/fp8_add_sequencer.sv
// fp8_add_sequencer
//   Operand-capture / result-handshake controller wrapped around a
//   combinational FP8 (E5M2) adder. Two operand bytes arrive serially
//   (A then B, op select sampled with B). The operands are held on the
//   adder inputs for SETTLE_CYCLES clocks, then the adder result is
//   registered and offered on a valid/ready output.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   abort               synchronous clear of the transaction in flight
//   in_data/in_subtract operand beat and op select (select used on B beat)
//   in_valid/in_ready   operand handshake
//   add_a/add_b/add_subtract  held operands driving the adder
//   add_result          adder output
//   out_data/out_valid/out_ready  result handshake
//   busy                high whenever not waiting for operand A
//   ops_done            wrapping count of completed result handshakes
module fp8_add_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_subtract,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_subtract,
  input  logic [WIDTH-1:0]       add_result,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] ops_done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("fp8_add_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       add_a_q, add_a_d;
  logic [WIDTH-1:0]       add_b_q, add_b_d;
  logic                   add_sub_q, add_sub_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [COUNT_WIDTH-1:0] ops_q, ops_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;

  // Handshake outputs are pure decodes of registered state, so there is
  // no combinational path from any input to in_ready or out_*.
  assign in_ready     = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy         = (state_q != LOAD_A);
  assign accept       = in_valid && in_ready;
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign add_subtract = add_sub_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign ops_done     = ops_q;

  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_sub_d   = add_sub_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ops_d       = ops_q;
    cnt_d       = cnt_q;
    if (abort) begin
      // Abort wins over any beat or result handshake in the same cycle;
      // held operands, last result and the counter are left untouched.
      state_d     = LOAD_A;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (accept) begin
            add_a_d = in_data;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            add_b_d   = in_data;
            add_sub_d = in_subtract;
            cnt_d     = CNT_LOAD;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            out_data_d  = add_result;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            ops_d       = ops_q + 1'b1;
            state_d     = LOAD_A;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_sub_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ops_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_sub_q   <= add_sub_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ops_q       <= ops_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// tb_fp8_add_sequencer
//   Directed bench for fp8_add_sequencer. Two instances are used: one with
//   SETTLE_CYCLES=1 and one with SETTLE_CYCLES=3; `sel` steers in_valid to
//   one of them and muxes its outputs onto the m_* observation signals.
//   Each instance drives a behavioural stand-in for the fp_add datapath.
module tb_fp8_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_subtract = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       sel = 1'b0;

  logic       in_valid1, in_ready1, add_sub1, out_valid1, busy1;
  logic [7:0] add_a1, add_b1, add_res1, out_data1, ops1;
  logic       in_valid3, in_ready3, add_sub3, out_valid3, busy3;
  logic [7:0] add_a3, add_b3, add_res3, out_data3, ops3;

  logic       m_in_ready, m_out_valid, m_busy;
  logic [7:0] m_add_a, m_add_b, m_out_data, m_ops;

  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_ops[2];

  always #5 clk = ~clk;

  // Adder stand-in: exact E5M2 results for the directed operand pairs,
  // an arbitrary but deterministic mixing function otherwise.
  function automatic logic [7:0] fp_model(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    if (a == 8'h3C && b == 8'h3C && !s) return 8'h40;
    if (a == 8'h40 && b == 8'h3C && s)  return 8'h3C;
    if (a == 8'h3E && b == 8'h3E && !s) return 8'h42;
    return (a ^ {b[3:0], b[7:4]}) + {7'd0, s} + 8'h11;
  endfunction

  assign in_valid1 = in_valid & ~sel;
  assign in_valid3 = in_valid & sel;
  assign add_res1  = fp_model(add_a1, add_b1, add_sub1);
  assign add_res3  = fp_model(add_a3, add_b3, add_sub3);

  assign m_in_ready  = sel ? in_ready3  : in_ready1;
  assign m_out_valid = sel ? out_valid3 : out_valid1;
  assign m_busy      = sel ? busy3      : busy1;
  assign m_add_a     = sel ? add_a3     : add_a1;
  assign m_add_b     = sel ? add_b3     : add_b1;
  assign m_out_data  = sel ? out_data3  : out_data1;
  assign m_ops       = sel ? ops3       : ops1;

  fp8_add_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .COUNT_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_data(in_data),
    .in_subtract(in_subtract), .in_valid(in_valid1), .in_ready(in_ready1),
    .add_a(add_a1), .add_b(add_b1), .add_subtract(add_sub1),
    .add_result(add_res1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1), .ops_done(ops1));

  fp8_add_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3), .COUNT_WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_data(in_data),
    .in_subtract(in_subtract), .in_valid(in_valid3), .in_ready(in_ready3),
    .add_a(add_a3), .add_b(add_b3), .add_subtract(add_sub3),
    .add_result(add_res3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .busy(busy3), .ops_done(ops3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s);
    check("in_ready_at_beat", 32'(m_in_ready), 32'd1);
    in_data     = d;
    in_subtract = s;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic s);
    send_beat(a, 1'b0);
    send_beat(b, s);
    exp_q.push_back(fp_model(a, b, s));
    check("add_a_captured", 32'(m_add_a), 32'(a));
    check("add_b_captured", 32'(m_add_b), 32'(b));
  endtask

  // Counts edges after the B beat until out_valid appears (bounded).
  task automatic wait_valid(input int lat);
    int cyc = 0;
    while (m_out_valid !== 1'b1 && cyc < 40) begin
      check("in_ready_low_in_settle", 32'(m_in_ready), 32'd0);
      step();
      cyc++;
    end
    check("result_latency", 32'(cyc), 32'(lat));
  endtask

  // Consumes the result with out_ready high and checks the handshake effects.
  task automatic take_result();
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check("out_data", 32'(m_out_data), 32'(e));
    check("in_ready_low_in_hold", 32'(m_in_ready), 32'd0);
    step();
    exp_ops[sel] = exp_ops[sel] + 8'd1;
    check("ops_done", 32'(m_ops), 32'(exp_ops[sel]));
    check("out_valid_cleared", 32'(m_out_valid), 32'd0);
    $display("txn dut%0d result=%02h ops_done=%02h", sel ? 3 : 1, m_out_data, m_ops);
  endtask

  initial begin
    logic [7:0] held;
    exp_ops[0] = 8'd0;
    exp_ops[1] = 8'd0;

    // Reset values while rst_n is held low.
    #3;
    check("rst_in_ready", 32'(m_in_ready), 32'd1);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_add_a", 32'(m_add_a), 32'd0);
    check("rst_out_data", 32'(m_out_data), 32'd0);
    check("rst_ops_done", 32'(m_ops), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // 1.0 + 1.0 = 2.0, single-cycle settle.
    out_ready = 1'b1;
    send_beat(8'h3C, 1'b0);
    check("busy_in_load_b", 32'(m_busy), 32'd1);
    send_beat(8'h3C, 1'b0);
    exp_q.push_back(fp_model(8'h3C, 8'h3C, 1'b0));
    check("t1_add_a", 32'(m_add_a), 32'h3C);
    check("t1_add_b", 32'(m_add_b), 32'h3C);
    wait_valid(1);
    take_result();

    // 2.0 - 1.0 = 1.0 on the three-cycle-settle instance.
    sel = 1'b1;
    send_pair(8'h40, 8'h3C, 1'b1);
    wait_valid(3);
    take_result();
    sel = 1'b0;

    // Result held under back-pressure; operand beats ignored in HOLD.
    out_ready = 1'b0;
    send_pair(8'h3E, 8'h3E, 1'b0);
    wait_valid(1);
    held = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", 32'(m_out_valid), 32'd1);
      check("hold_out_data", 32'(m_out_data), 32'(held));
      check("hold_ops_done", 32'(m_ops), 32'(exp_ops[0]));
      in_data  = 8'h55;
      in_valid = i[0];
      step();
    end
    in_valid = 1'b0;
    check("hold_add_a", 32'(m_add_a), 32'h3E);
    check("hold_add_b", 32'(m_add_b), 32'h3E);
    out_ready = 1'b1;
    step();
    exp_ops[0] = exp_ops[0] + 8'd1;
    check("hold_release_ops", 32'(m_ops), 32'(exp_ops[0]));
    check("hold_release_valid", 32'(m_out_valid), 32'd0);

    // Abort in LOAD_B with a B beat presented: beat dropped.
    send_beat(8'h11, 1'b0);
    in_data  = 8'h22;
    in_valid = 1'b1;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_add_b_kept", 32'(m_add_b), 32'h3E);
    check("abort_add_a_kept", 32'(m_add_a), 32'h11);
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_in_ready", 32'(m_in_ready), 32'd1);
    send_pair(8'h12, 8'h34, 1'b1);
    wait_valid(1);
    take_result();

    // Abort in HOLD together with out_ready: handshake not counted.
    out_ready = 1'b0;
    send_pair(8'h21, 8'h43, 1'b0);
    wait_valid(1);
    held      = exp_q.pop_front();
    abort     = 1'b1;
    out_ready = 1'b1;
    step();
    abort     = 1'b0;
    check("abort_hold_valid", 32'(m_out_valid), 32'd0);
    check("abort_hold_ops", 32'(m_ops), 32'(exp_ops[0]));
    check("abort_hold_data_kept", 32'(m_out_data), 32'(held));
    check("abort_hold_in_ready", 32'(m_in_ready), 32'd1);

    // Asynchronous reset mid-SETTLE on the three-cycle instance.
    sel = 1'b1;
    send_pair(8'h3C, 8'h3C, 1'b0);
    step();
    void'(exp_q.pop_front());
    #2 rst_n = 1'b0;
    #1;
    exp_ops[0] = 8'd0;
    exp_ops[1] = 8'd0;
    check("arst_out_valid", 32'(m_out_valid), 32'd0);
    check("arst_add_a", 32'(m_add_a), 32'd0);
    check("arst_add_b", 32'(m_add_b), 32'd0);
    check("arst_busy", 32'(m_busy), 32'd0);
    check("arst_in_ready", 32'(m_in_ready), 32'd1);
    check("arst_ops_done", 32'(m_ops), 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("arst_out_valid_stays", 32'(m_out_valid), 32'd0);
    end
    sel = 1'b0;

    // 256 back-to-back transactions: ops_done wraps 0xFF -> 0x00.
    for (int i = 0; i < 256; i++) begin
      send_pair(8'($urandom), 8'($urandom), 1'($urandom));
      wait_valid(1);
      take_result();
    end
    check("wrap_ops_done_zero", 32'(m_ops), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fp8_add_sequencer.md
Name: fp8_add_sequencer

Overview:
- Operand-capture and result-handshake controller that sits directly upstream and downstream of the combinational fp_add datapath.
- Accepts two FP8 E5M2 operands serially over a byte-wide valid/ready interface, with the operation select sampled alongside operand B.
- Holds the operands stable on the adder inputs for a programmable settle window, then registers the adder result.
- Presents the result on an output valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width; must equal the fp_add WIDTH.
- SETTLE_CYCLES, 1, clock cycles the adder inputs are held before the result is sampled; legal range 1..15.
- COUNT_WIDTH, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous clear of the transaction in flight.
- in_data  in  WIDTH  operand byte; first beat is A, second beat is B.
- in_subtract  in  1  operation select; 1 = A−B, sampled only on the B beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  sequencer can accept a beat.
- add_a  out  WIDTH  to fp_add a.
- add_b  out  WIDTH  to fp_add b.
- add_subtract  out  1  to fp_add subtract.
- add_result  in  WIDTH  from fp_add result.
- out_data  out  WIDTH  registered result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- busy  out  1  high in every state except LOAD_A.
- ops_done  out  COUNT_WIDTH  count of completed result handshakes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = LOAD_A.
  - add_a, add_b, add_subtract, out_data, ops_done, settle counter = 0.
  - out_valid = 0. in_ready = 1. busy = 0.
- States: LOAD_A, LOAD_B, SETTLE, HOLD. in_ready is a decode of state: 1 in LOAD_A/LOAD_B, 0 in SETTLE/HOLD.
- A beat is accepted on a rising edge where in_valid && in_ready.
- LOAD_A: on accept, add_a <= in_data; go to LOAD_B.
- LOAD_B: on accept, add_b <= in_data, add_subtract <= in_subtract, counter <= SETTLE_CYCLES−1; go to SETTLE.
- SETTLE:
  - If counter ≠ 0, decrement.
  - If counter == 0, out_data <= add_result, out_valid <= 1; go to HOLD.
  - Latency: if B is accepted at edge k, out_valid rises after edge k+SETTLE_CYCLES.
- HOLD:
  - out_valid = 1, out_data stable.
  - On out_valid && out_ready: out_valid <= 0, ops_done <= ops_done+1 (wraps 2^COUNT_WIDTH−1 → 0); go to LOAD_A.
  - Without out_ready, remain in HOLD indefinitely.
- add_a/add_b/add_subtract change only on their accepting edge. They remain stable through SETTLE and HOLD and keep their last values after returning to LOAD_A.
- abort (synchronous, highest priority):
  - Next state = LOAD_A, out_valid <= 0, counter <= 0.
  - add_*, out_data and ops_done are not modified.
  - A beat or result handshake presented in the same cycle is dropped and not counted.
- in_valid while in_ready = 0 is ignored; no buffering, data is not captured.
- Asserting rst_n low mid-transaction discards all state immediately.
- Result rises from the state register only: no combinational path from in_* or out_ready to out_* or in_ready.
- SETTLE_CYCLES outside 1..15 is an elaboration error.
- The counter is $clog2(SETTLE_CYCLES+1) bits wide.

Test Plan:
- Reset, then A=0x3C, B=0x3C, in_subtract=0 with an fp_add instance attached, out_ready=1 → add_a=0x3C, add_b=0x3C; out_valid rises 1 cycle after the B beat with out_data=0x40 (2.0); ops_done=1.
- A=0x40, B=0x3C, in_subtract=1, SETTLE_CYCLES=3 → out_valid rises exactly 3 edges after the B beat; out_data=0x3C; in_ready=0 throughout SETTLE/HOLD.
- A=0x3E, B=0x3E, add, with out_ready held low 10 cycles → out_data=0x42 held stable and out_valid=1 for all 10 cycles. in_valid pulses during HOLD are ignored and add_a stays 0x3E. ops_done increments only on the out_ready edge.
- abort asserted in LOAD_B together with in_valid → B not captured, state LOAD_A, busy=0. A new A/B pair completes correctly afterwards.
- rst_n pulsed low asynchronously mid-SETTLE → all outputs return to reset values without a clock edge; out_valid stays 0 after release.
- 256 back-to-back transactions with COUNT_WIDTH=8 → ops_done wraps from 0xFF to 0x00.
